cla_nibble_subtractor: RTL and testbench
========================================

// Module: cla_nibble_subtractor
// PURPOSE
//  Multi-cycle W-bit subtractor: D = A - B - Bin, one 4-bit carry-lookahead slice per clock.
//  Datapath per slice: A + ~B + ~borrow, with G/P lookahead inside the nibble.
//  Borrow is registered between slices. Valid/ready handshake on both sides.
//  Sits beside the 4-bit CLA adder as the arithmetic-inverse unit for the datapath.
// PARAMETERS
//  W       16  operand width; multiple of 4, >= 4.
//  NSLICE  W/4 derived (localparam); number of nibble slices.
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  a/b/bin valid
//  in_ready   out  1  block can accept operands
//  a          in   W  minuend (unsigned, or two's-complement signed)
//  b          in   W  subtrahend
//  bin        in   1  borrow-in
//  out_valid  out  1  diff/bout/ovf valid
//  out_ready  in   1  consumer accepts result
//  diff       out  W  A - B - Bin, modulo 2^W
//  bout       out  1  unsigned borrow-out (1 = A < B + Bin)
//  ovf        out  1  signed overflow
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, slice idx=0.
//  FSM IDLE -> RUN -> DONE -> IDLE. Registered outputs only; no comb path in->out.
//  IDLE
//   - in_ready=1.
//   - in_valid=1: latch a, b, borrow reg = bin, idx=0, go RUN.
//  RUN
//   - in_ready=0.
//   - Each cycle on slice k=idx: s = a[4k+:4] + ~b[4k+:4] + !borrow (5-bit).
//   - diff[4k+:4] <= s[3:0]; borrow <= !s[4]; idx++.
//   - At idx=NSLICE-1, go DONE. bout = final borrow.
//   - ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]), computed on final slice.
//  DONE
//   - out_valid=1; hold until out_ready=1, then IDLE next cycle.
//  Latency: operands accepted at edge T0; out_valid=1 after edge T0+NSLICE (W=16: 4 cycles).
//  Throughput: one op per NSLICE+2 cycles with out_ready tied high.
//  Back-pressure: DONE holds diff/bout/ovf stable while out_ready=0; in_ready stays 0.
//  No accept during the output-handshake cycle; in_ready rises the cycle after.
//  out_ready while not in DONE is ignored. in_valid while in_ready=0 is ignored (no capture).
//  Wrap-around: diff is modulo 2^W, e.g. 0-1 gives all ones with bout=1.
//  Reset mid-RUN/DONE: operation discarded; next cycle is IDLE with reset values.
//  W=4: single RUN cycle (NSLICE=1).
// CONFIGURATION
//  CLA_SUB_SATURATE_EN
//   - Defined: if ovf=1 at completion, diff is replaced by the signed limit.
//     a[W-1]=0 gives 2^(W-1)-1; a[W-1]=1 gives -2^(W-1).
//     ovf and bout are still reported unmodified. Adds no latency (applied on final slice).
//   - Undefined: diff is always the wrapped result.
// TESTING (W=16)
//  1. a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0.
//     out_valid exactly 4 cycles after accept.
//  2. a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1, ovf=0.
//     a=0x1000, b=0x0001 -> diff=0x0FFF (borrow ripples across 3 slices).
//  3. a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0.
//     a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1.
//  4. a=0x8000, b=0x0001 -> ovf=1, bout=0; diff=0x7FFF (wrap) / 0x8000 (SAT_EN).
//     a=0x7FFF, b=0xFFFF -> ovf=1, bout=1; diff=0x8000 (wrap) / 0x7FFF (SAT_EN).
//  5. Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0.
//     Toggle in_valid meanwhile -> no capture. Release -> IDLE; next op result correct.
//  6. Assert rst on 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, diff=0.
//     Following op a=0x0010, b=0x0001 -> diff=0x000F.

Source files
------------

// File: rtl/cla_nibble_subtractor.sv
// cla_nibble_subtractor
//   Multi-cycle W-bit subtractor, D = A - B - Bin, resolved one 4-bit
//   carry-lookahead nibble per clock with the borrow registered between
//   nibbles. Valid/ready handshake on both operand and result sides.
//   Optional feature macro: CLA_SUB_SATURATE_EN (clamp diff to the signed
//   limit when signed overflow is detected).
module cla_nibble_subtractor #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int NSLICE = W / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_borrow;
  logic [IDX_W-1:0] r_idx;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_sum;
  logic             w_borrow_out;
  logic [W-1:0]     w_diff_wrap;
  logic [W-1:0]     w_diff_final;
  logic             w_ovf;
  logic             w_last;
  logic             w_accept;

  // 4-bit carry-lookahead add: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Signed limit in the direction of the minuend's sign:
  // non-negative minuend clamps to max positive, negative to most negative.
  function automatic logic [W-1:0] sat_limit(input logic minuend_neg);
    logic signed [W-1:0] lim;
    if (minuend_neg) lim = {1'b1, {(W-1){1'b0}}};
    else             lim = {1'b0, {(W-1){1'b1}}};
    return lim;
  endfunction

  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Select the active nibble of both operands.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_nib = r_a[4*k +: 4];
        w_b_nib = r_b[4*k +: 4];
      end
    end
  end

  // Subtract as A + ~B + ~borrow; a carry out means no borrow out.
  assign w_sum        = cla4(w_a_nib, ~w_b_nib, ~r_borrow);
  assign w_borrow_out = ~w_sum[4];

  // Merge the new nibble into the partially built difference word.
  always_comb begin
    w_diff_wrap = diff;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_diff_wrap[4*k +: 4] = w_sum[3:0];
      end
    end
  end

  // Overflow only when operand signs differ and the result sign leaves A's.
  assign w_ovf = (r_a[W-1] != r_b[W-1]) && (w_diff_wrap[W-1] != r_a[W-1]);

`ifdef CLA_SUB_SATURATE_EN
  assign w_diff_final = w_ovf ? sat_limit(r_a[W-1]) : w_diff_wrap;
`else
  assign w_diff_final = w_diff_wrap;
`endif

  // Operand capture; data registers need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      r_idx     <= '0;
      r_borrow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_borrow <= bin;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_borrow <= w_borrow_out;
          if (w_last) begin
            diff      <= w_diff_final;
            bout      <= w_borrow_out;
            ovf       <= w_ovf;
            out_valid <= 1'b1;
            r_idx     <= '0;
            r_state   <= S_DONE;
          end else begin
            diff  <= w_diff_wrap;
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_subtractor.sv
// tb_cla_nibble_subtractor
//   Scoreboard bench for cla_nibble_subtractor (W=16). The driver pushes
//   hand-computed expected results; a monitor pops and compares on each
//   output handshake and checks accept-to-valid latency.
module tb_cla_nibble_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

`ifdef CLA_SUB_SATURATE_EN
  localparam logic [15:0] E4A = 16'h8000;
  localparam logic [15:0] E4B = 16'h7FFF;
`else
  localparam logic [15:0] E4A = 16'h7FFF;
  localparam logic [15:0] E4B = 16'h8000;
`endif

  cla_nibble_subtractor #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                      input logic [15:0] ed, input logic eb, input logic eo, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a        = ta;
    b        = tb_;
    bin      = tbin;
    in_valid = 1'b1;
    if (push) q.push_back('{ed, eb, eo, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Monitor: latency on each rising out_valid, payload on each handshake.
  initial begin
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && !prev_ov) begin
        if (q.size() != 0) chk("latency", 32'(cyc - q[0].acc), 32'd4);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got diff=%h with no result expected", diff);
        end else begin
          e = q.pop_front();
          chk("diff", 32'(diff), 32'(e.d));
          chk("bout", 32'(bout), 32'(e.bo));
          chk("ovf",  32'(ovf),  32'(e.ov));
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff",      32'(diff),      32'd0);
    chk("rst_bout",      32'(bout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    rst = 1'b0;

    // Basic, wrap, ripple, borrow-in and overflow vectors
    send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    send(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, E4A,      1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'hFFFF, 1'b0, E4B,      1'b1, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    drain();

    // Back-pressure: hold DONE for 3 cycles while poking in_valid
    out_ready = 1'b0;
    send(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_diff",      32'(diff),      32'h00F0);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      a        = 16'hFFFF;
      b        = 16'h0000;
      in_valid = (i != 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready",  32'(in_ready),  32'd1);
    send(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset on the second RUN cycle discards the operation
    send(16'h1234, 16'h0234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff",      32'(diff),      32'd0);
    send(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b1);
    drain();

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
